// File: rtl/switch_input_pkg.sv
// Shared constants and helpers for the switch input conditioner.
// Used by switch_input_conditioner and debounce_channel.
package switch_input_pkg;

  // 10 ms of stability at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // Counter width needed to reach cycles-1, never less than one bit
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter, stable level
// and optional rise/fall pulses (pulses generated only with SWITCH_EDGE_PULSE_EN).
module debounce_channel
  import switch_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic             stable_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             differ;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= sw;
      sync2_reg <= sync1_reg;
    end
  end

  // Any return to the stable level clears the count; it never wraps
  always_comb begin
    differ      = (sync2_reg != stable_reg);
    accept      = differ && (cnt_reg == CNT_MAX);
    cnt_next    = '0;
    stable_next = stable_reg;
    if (accept) begin
      stable_next = sync2_reg;
    end else if (differ) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
    end
  end

  assign stable = stable_reg;

`ifdef SWITCH_EDGE_PULSE_EN
  logic rise_reg;
  logic fall_reg;

  // Pulses register on the same edge that updates the stable level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= accept &  sync2_reg;
      fall_reg <= accept & ~sync2_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_input_conditioner.sv
// Synchronises and debounces NUM_CH raw switch/button pins into clean levels.
// Rise/fall pulses are active only when SWITCH_EDGE_PULSE_EN is defined.
module switch_input_conditioner
  import switch_input_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              I_P_CLK,
  input  logic              I_P_RST,
  input  logic [NUM_CH-1:0] I_P_SW,
  output logic [NUM_CH-1:0] O_P_STABLE,
  output logic [NUM_CH-1:0] O_P_RISE,
  output logic [NUM_CH-1:0] O_P_FALL
);

  // Channels are independent; simultaneous acceptances pulse together
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_channel (
        .clk   (I_P_CLK),
        .rst   (I_P_RST),
        .sw    (I_P_SW[gi]),
        .stable(O_P_STABLE[gi]),
        .rise  (O_P_RISE[gi]),
        .fall  (O_P_FALL[gi])
      );
    end
  endgenerate

endmodule
